// File: rtl/maze_loader.sv
// maze_loader: accepts a maze as a stream of row words and serialises each row
// into one-cell-per-clock writes for the maze memory, rejecting mazes whose start or goal is a wall.
module maze_loader #(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [N-1:0]             rowIn,
    input  logic                     rowValid,
    output logic                     rowReady,
    output logic [2*$clog2(N)-1:0]   loc,
    output logic                     dOut,
    output logic                     wr,
    output logic                     busy,
    output logic                     done,
    output logic                     fail
);

    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        WRITE,
        DONE,
        FAIL
    } state_e;

    state_e         state_q, state_d;
    logic [LW-1:0]  row_q, row_d;
    logic [LW-1:0]  col_q, col_d;
    logic [N-1:0]   shift_q, shift_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (load) begin
                    state_d = WAIT_ROW;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            WAIT_ROW: begin
                if (rowValid) begin
                    shift_d = rowIn;
                    // A wall on the start or goal cell rejects the maze before anything of that row is written.
                    if ((row_q == '0 && rowIn[0]) || (row_q == LAST && rowIn[N-1])) begin
                        state_d = FAIL;
                    end else begin
                        state_d = WRITE;
                        col_d   = '0;
                    end
                end
            end
            WRITE: begin
                shift_d = shift_q >> 1;
                col_d   = col_q + 1'b1;
                if (col_q == LAST) begin
                    col_d = '0;
                    if (row_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = WAIT_ROW;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output comes from registers only, so there is no combinational path from any input.
    assign loc      = {row_q, col_q};
    assign dOut     = shift_q[0];
    assign wr       = (state_q == WRITE);
    assign rowReady = (state_q == WAIT_ROW);
    assign busy     = (state_q == WAIT_ROW) || (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign fail     = (state_q == FAIL);

endmodule

// File: tb/tb_maze_loader.sv
// tb_maze_loader: self-checking bench for maze_loader with a table of single-row
// vectors, a queue-based write scoreboard, and randomized mazes and producer stalls.
module tb_maze_loader;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] rowIn = '0;
    logic         rowValid = 1'b0;
    logic         rowReady;
    logic [7:0]   loc;
    logic         dOut;
    logic         wr;
    logic         busy;
    logic         done;
    logic         fail;

    int checkCount = 0;
    int failCount = 0;

    logic [N-1:0] maze [N];

    typedef struct {
        logic [N-1:0] row0;
        logic         expFail;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    maze_loader #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .rowIn    (rowIn),
        .rowValid (rowValid),
        .rowReady (rowReady),
        .loc      (loc),
        .dOut     (dOut),
        .wr       (wr),
        .busy     (busy),
        .done     (done),
        .fail     (fail)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        load = 1'b0;
        rowValid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic clearMaze();
        for (int r = 0; r < N; r++) maze[r] = '0;
    endtask

    // Runs one complete load of 'maze' and checks every write against a list of
    // expected (address, data) pairs derived directly from the maze contents.
    task automatic applyStimulus(input string tag, input int stallPct, input int gapRow,
                                 input int gapLen, input bit midLoad);
        logic [7:0] expLoc [$];
        logic       expD [$];
        logic [7:0] eLoc;
        logic       eD;
        bit         expFail = 1'b0;
        bit         stalledPrev = 1'b0;
        int         rowsOk = 0;
        int         cycle = 0;
        int         stalls = 0;
        int         gapCnt = 0;
        int         rowIdx = 0;
        int         writes = 0;
        int         endCycle;

        for (int r = 0; r < N; r++) begin
            if ((r == 0 && maze[r][0]) || (r == N - 1 && maze[r][N-1])) begin
                expFail = 1'b1;
                break;
            end
            rowsOk++;
            for (int c = 0; c < N; c++) begin
                expLoc.push_back(8'(r * N + c));
                expD.push_back(maze[r][c]);
            end
        end

        load = 1'b1;
        rowValid = 1'b0;
        stepCycle();
        load = 1'b0;
        cycle = 1;
        checkOutput({tag, " rowReady after load"}, 32'(rowReady), 32'd1);
        checkOutput({tag, " done cleared by load"}, 32'(done), 32'd0);
        checkOutput({tag, " fail cleared by load"}, 32'(fail), 32'd0);

        while (!(done || fail) && cycle < 1000) begin
            if (stalledPrev) checkOutput({tag, " rowReady held in stall"}, 32'(rowReady), 32'd1);
            if (wr) begin
                writes++;
                if (expLoc.size() > 0) begin
                    eLoc = expLoc.pop_front();
                    eD = expD.pop_front();
                    checkOutput({tag, " write loc"}, 32'(loc), 32'(eLoc));
                    checkOutput({tag, " write dOut"}, 32'(dOut), 32'(eD));
                end
            end
            load = (midLoad && wr && loc == 8'h37);
            stalledPrev = 1'b0;
            if (rowReady && ((rowIdx == gapRow && gapCnt < gapLen) || $urandom_range(99) < stallPct)) begin
                if (rowIdx == gapRow) gapCnt++;
                rowValid = 1'b0;
                rowIn = N'($urandom);
                stalls++;
                stalledPrev = 1'b1;
            end else if (rowReady) begin
                rowValid = 1'b1;
                rowIn = maze[rowIdx < N ? rowIdx : N - 1];
                rowIdx++;
            end else begin
                rowValid = 1'b1;
                rowIn = N'($urandom);
            end
            stepCycle();
            cycle++;
        end
        load = 1'b0;
        rowValid = 1'b0;

        endCycle = rowsOk * (N + 1) + (expFail ? 2 : 1) + stalls;
        checkOutput({tag, " end cycle"}, 32'(cycle), 32'(endCycle));
        checkOutput({tag, " done"}, 32'(done), 32'(!expFail));
        checkOutput({tag, " fail"}, 32'(fail), 32'(expFail));
        checkOutput({tag, " busy at end"}, 32'(busy), 32'd0);
        checkOutput({tag, " wr at end"}, 32'(wr), 32'd0);
        checkOutput({tag, " write count"}, 32'(writes), 32'(rowsOk * N));
        checkOutput({tag, " writes left"}, 32'(expLoc.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{row0: 16'h0001, expFail: 1'b1};
        vecs[1] = '{row0: 16'h0000, expFail: 1'b0};
        vecs[2] = '{row0: 16'hFFFF, expFail: 1'b1};
        vecs[3] = '{row0: 16'hFFFE, expFail: 1'b0};
        vecs[4] = '{row0: 16'h8000, expFail: 1'b0};
        vecs[5] = '{row0: 16'h0003, expFail: 1'b1};

        #1;
        checkOutput("reset rowReady", 32'(rowReady), 32'd0);
        checkOutput("reset wr", 32'(wr), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset fail", 32'(fail), 32'd0);
        checkOutput("reset dOut", 32'(dOut), 32'd0);
        checkOutput("reset loc", 32'(loc), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Idle loader must ignore rowValid.
        rowValid = 1'b1;
        rowIn = 16'h1234;
        repeat (3) stepCycle();
        rowValid = 1'b0;
        checkOutput("idle ignores rowValid busy", 32'(busy), 32'd0);
        checkOutput("idle ignores rowValid wr", 32'(wr), 32'd0);

        $display("[TB] full load with row 5 = A5A4");
        clearMaze();
        maze[5] = 16'hA5A4;
        applyStimulus("full", 0, -1, 0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("done held", 32'(done), 32'd1);

        $display("[TB] reload from DONE with load pulsed mid-write");
        applyStimulus("midload", 0, -1, 0, 1'b1);

        $display("[TB] goal wall in row 15");
        clearMaze();
        for (int r = 0; r < N - 1; r++) maze[r] = N'($urandom) & 16'hFFFE;
        maze[N-1] = 16'h8000;
        applyStimulus("goalfail", 0, -1, 0, 1'b0);

        $display("[TB] producer gap before row 7");
        clearMaze();
        maze[7] = 16'h00FF;
        applyStimulus("gap", 0, 7, 10, 1'b0);

        $display("[TB] single-row start vectors");
        foreach (vecs[i]) begin
            applyReset();
            load = 1'b1;
            stepCycle();
            load = 1'b0;
            rowValid = 1'b1;
            rowIn = vecs[i].row0;
            stepCycle();
            rowValid = 1'b0;
            checkOutput($sformatf("vec%0d fail", i), 32'(fail), 32'(vecs[i].expFail));
            checkOutput($sformatf("vec%0d wr", i), 32'(wr), 32'(!vecs[i].expFail));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(!vecs[i].expFail));
            checkOutput($sformatf("vec%0d rowReady", i), 32'(rowReady), 32'd0);
            stepCycle();
            checkOutput($sformatf("vec%0d wr next", i), 32'(wr), 32'(!vecs[i].expFail));
        end

        $display("[TB] asynchronous reset during row 3 col 7");
        applyReset();
        clearMaze();
        load = 1'b1;
        stepCycle();
        load = 1'b0;
        rowValid = 1'b1;
        rowIn = '0;
        for (int g = 0; g < 200 && !(wr && loc == 8'h37); g++) stepCycle();
        checkOutput("reached row3 col7", 32'(loc), 32'h37);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset wr", 32'(wr), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset rowReady", 32'(rowReady), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset fail", 32'(fail), 32'd0);
        checkOutput("async reset loc", 32'(loc), 32'd0);
        #2 rst = 1'b1;
        rowValid = 1'b0;
        maze[3] = 16'h0F0F;
        applyStimulus("after reset", 0, -1, 0, 1'b0);

        $display("[TB] randomized mazes with random stalls");
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < N; r++) maze[r] = N'($urandom);
            if ($urandom_range(99) < 75) maze[0][0] = 1'b0;
            if ($urandom_range(99) < 75) maze[N-1][N-1] = 1'b0;
            applyStimulus($sformatf("rand%0d", t), 30, $urandom_range(N - 1), $urandom_range(5), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/maze_loader.md
# maze_loader

Writer side of the maze-memory interface. Accepts the maze as a stream of 16-bit row words over a valid/ready handshake and serialises each row into single-bit writes on the memory's `loc`/`dIn`/`wr` port, one cell per clock. It also rejects mazes whose start or goal cell is a wall. It sits in front of `mazeMemory` and runs before the solver is started. The solver's controller only reads the memory. The loader owns the write path while `busy` is high.

## Interface

Parameters:
- `N`, 16, grid dimension (cells per row and rows per maze); must be a power of 2; `loc` width is 2*log2(N).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load` in 1: start a new maze load; sampled only in IDLE, DONE and FAIL.
- `rowIn` in N: row word; bit c is column c (1 = wall, 0 = open).
- `rowValid` in 1: `rowIn` is valid.
- `rowReady` out 1: loader can accept a row this cycle.
- `loc` out 8: memory address = {row[3:0], col[3:0]} = row*N + col.
- `dOut` out 1: cell value to write; connects to the memory data input.
- `wr` out 1: memory write strobe, one cell per cycle.
- `busy` out 1: load in progress; the solver must not start while this is high.
- `done` out 1: maze fully written and valid; level held until the next load.
- `fail` out 1: maze rejected; level held until the next load.

## Operation

- States: IDLE, WAIT_ROW, WRITE, DONE, FAIL.
- IDLE:
  - `load`=1 → WAIT_ROW; clear `row` and `col` to 0.
- WAIT_ROW:
  - `rowReady`=1.
  - A transfer happens on `rowValid`&`rowReady`; `rowIn` is captured into the row shift register.
  - Start check: if row=0 and `rowIn[0]`=1 → FAIL.
  - Goal check: if row=N-1 and `rowIn[N-1]`=1 → FAIL.
  - A failing row is never written.
  - Otherwise → WRITE with col=0.
- WRITE:
  - `wr`=1, `loc`={row,col}, `dOut`=shift register bit 0.
  - Each cycle: shift register shifts right by one, col increments.
  - After col=N-1:
    - if row=N-1 → DONE;
    - else row increments → WAIT_ROW.
- DONE / FAIL:
  - `done` or `fail` held high.
  - `load`=1 clears both flags and `row`/`col`, then → WAIT_ROW.
- `load` in WAIT_ROW or WRITE is ignored; a load cannot be restarted mid-maze except by reset.
- `rowValid` outside WAIT_ROW is ignored; no data is captured.
- `busy` = state ∈ {WAIT_ROW, WRITE}.
- `rowReady` = (state == WAIT_ROW).
- `wr` = (state == WRITE).
- `col` wraps from N-1 to 0 only on a row transition. `row` never wraps, because DONE is reached at N-1.
- Cells in rows before a failing row stay written; the memory is not scrubbed.

## Timing

- Reset value of all outputs: `rowReady`, `wr`, `busy`, `done`, `fail`, `dOut` = 0; `loc` = 0; state = IDLE.
- Reset is asynchronous. Asserting `rst` mid-WRITE drops `wr` immediately, without waiting for a clock edge.
- Every output is registered or decoded from state only; there are no combinational input-to-output paths. This includes `rowReady`, which does not depend on `rowValid`.
- `load` sampled at edge k → `rowReady`=1 in cycle k+1.
- A row accepted at edge j produces writes in cycles j+1 … j+N, with `loc` incrementing by 1 per cycle. WAIT_ROW (`rowReady`=1) follows in cycle j+N+1.
- Minimum full load with `rowValid` held high: N*(N+1) cycles from `load`. `done` rises in cycle N*(N+1)+1 (cycle 273 for N=16).
- The producer may stall arbitrarily in WAIT_ROW; no timeout.
- FAIL is entered the cycle after the offending handshake; `wr` never asserts for that row.

## Test plan

- Reset during WRITE of row 3, col 7 → `wr`, `busy`, `rowReady`, `done`, `fail` = 0 asynchronously. A subsequent `load` restarts at `loc`=0x00.
- Full load, `rowValid` always high, row r = 16'h0000 except row 5 = 16'hA5A4:
  - 256 writes occur, `loc` 0x00 … 0xFF in order;
  - `dOut`=1 exactly at `loc` 0x52, 0x55, 0x57, 0x58, 0x5A, 0x5D, 0x5F;
  - `done` rises at cycle 273;
  - `fail` stays 0.
- Row 0 = 16'h0001 → `fail`=1 the next cycle, zero `wr` pulses, `busy`=0.
- Rows 0–14 valid, row 15 = 16'h8000 → 240 writes, then `fail`=1, `done`=0, no writes to `loc` 0xF0–0xFF.
- Producer drops `rowValid` for 10 cycles before row 7 → `rowReady` held high, no writes during the gap, `loc` resumes at 0x70.
- `load` pulsed mid-WRITE → ignored: the write sequence is unchanged. `load` pulsed after DONE → `done` clears, `rowReady`=1 next cycle, and reload restarts at `loc` 0x00.
